// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: None tag, default widths and producer port indices.
// Optional flush support is compiled in with CDB_ARB_FLUSH_EN.
package cdb_arbiter_pkg;

   localparam int TAG_NONE   = 0;
   localparam int TAG_W_DEF  = 4;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      PORT_ALU = 3'd0,
      PORT_LSB = 3'd1,
      PORT_BR  = 3'd2
   } port_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest request at or above the pointer,
// wrapping to the lowest request overall when nothing sits above it.
module cdb_arbiter_rr_pick
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic             o_any
);

   logic [N_REQ-1:0] w_mask;
   logic [N_REQ-1:0] w_hi;
   logic [N_REQ-1:0] w_sel;

   // w_mask keeps positions >= i_ptr
   assign w_mask  = ~((N_REQ'(1) << i_ptr) - N_REQ'(1));
   assign w_hi    = i_req & w_mask;
   assign w_sel   = (|w_hi) ? w_hi : i_req;
   assign o_grant = w_sel & (~w_sel + N_REQ'(1));
   assign o_any   = |i_req;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry slot per producer, round-robin broadcast onto
// registered CDB outputs. Define CDB_ARB_FLUSH_EN to add the flush_in port.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*TAG_W-1:0]    req_tag,
   input  logic [N_REQ*DATA_W-1:0]   req_val,
   input  logic [N_REQ*DATA_W-1:0]   req_addr,
   output logic [N_REQ-1:0]          req_ready,
`ifdef CDB_ARB_FLUSH_EN
   input  logic                      flush_in,
`endif
   output logic                      cdb_active,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_val,
   output logic [DATA_W-1:0]         cdb_addr
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]              r_full;
   logic [N_REQ-1:0][TAG_W-1:0]   r_tag;
   logic [N_REQ-1:0][DATA_W-1:0]  r_val;
   logic [N_REQ-1:0][DATA_W-1:0]  r_addr;
   logic [IW-1:0]                 r_ptr;

   logic [N_REQ-1:0][TAG_W-1:0]   w_in_tag;
   logic [N_REQ-1:0][DATA_W-1:0]  w_in_val;
   logic [N_REQ-1:0][DATA_W-1:0]  w_in_addr;
   logic [N_REQ-1:0]              w_live;
   logic [N_REQ-1:0]              w_drop;
   logic [N_REQ-1:0]              w_pick;
   logic [N_REQ-1:0]              w_grant;
   logic [N_REQ-1:0]              w_acc;
   logic                          w_any;
   logic                          w_flush;
   logic                          w_go;
   logic [IW-1:0]                 w_gidx;
   logic [IW-1:0]                 w_ptr_nxt;
   logic [TAG_W-1:0]              w_btag;
   logic [DATA_W-1:0]             w_bval;
   logic [DATA_W-1:0]             w_baddr;

`ifdef CDB_ARB_FLUSH_EN
   assign w_flush = flush_in;
`else
   assign w_flush = 1'b0;
`endif

   assign w_in_tag  = req_tag;
   assign w_in_val  = req_val;
   assign w_in_addr = req_addr;
   assign w_go      = rdy_in & ~w_flush;

   cdb_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .i_req   (w_live),
      .i_ptr   (r_ptr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   assign w_grant   = w_go ? w_pick : '0;
   // reset gating keeps ready low while rst_in is held, independent of slot state
   assign req_ready = {N_REQ{rst_in & w_go}} & (~r_full | w_grant);
   assign w_acc     = req_valid & req_ready;

   always_comb begin
      w_gidx  = '0;
      w_btag  = '0;
      w_bval  = '0;
      w_baddr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick[i]) begin
            w_gidx  = IW'(i);
            w_btag  = r_tag[i];
            w_bval  = r_val[i];
            w_baddr = r_addr[i];
         end
      end
   end

   assign w_ptr_nxt = (w_gidx == IW'(N_REQ - 1)) ? '0 : w_gidx + IW'(1);

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slot
         // tag-0 slots are never picked and fall out at the following edge
         assign w_live[gi] = r_full[gi] && (r_tag[gi] != TAG_W'(TAG_NONE));
         assign w_drop[gi] = r_full[gi] && (r_tag[gi] == TAG_W'(TAG_NONE));

         always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
               r_full[gi] <= 1'b0;
               r_tag[gi]  <= '0;
               r_val[gi]  <= '0;
               r_addr[gi] <= '0;
            end else if (rdy_in) begin
               if (w_flush) begin
                  r_full[gi] <= 1'b0;
               end else if (w_acc[gi]) begin
                  r_full[gi] <= 1'b1;
                  r_tag[gi]  <= w_in_tag[gi];
                  r_val[gi]  <= w_in_val[gi];
                  r_addr[gi] <= w_in_addr[gi];
               end else if (w_grant[gi] || w_drop[gi]) begin
                  r_full[gi] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_ptr      <= '0;
         cdb_active <= 1'b0;
         cdb_tag    <= '0;
         cdb_val    <= '0;
         cdb_addr   <= '0;
      end else if (rdy_in) begin
         if (w_flush) begin
            r_ptr      <= '0;
            cdb_active <= 1'b0;
            cdb_tag    <= '0;
            cdb_val    <= '0;
            cdb_addr   <= '0;
         end else begin
            if (w_any) r_ptr <= w_ptr_nxt;
            cdb_active <= w_any;
            cdb_tag    <= w_btag;
            cdb_val    <= w_bval;
            cdb_addr   <= w_baddr;
         end
      end
   end

endmodule
